// File: rtl/hex_display_if.sv
// Bus between the CPU display register and hex_display_ctrl.
// With HEX_DISPLAY_BLINK_EN defined the bus also carries the blink request.
interface hex_display_if #(
    parameter int NUM_DIGITS = 6
);
    localparam int DATA_W = 4 * NUM_DIGITS;

    logic                    load;
    logic [DATA_W-1:0]       value;
    logic                    dec_mode;
    logic                    blank_lz;
`ifdef HEX_DISPLAY_BLINK_EN
    logic                    blink;
`endif
    logic                    busy;
    logic [7*NUM_DIGITS-1:0] HEX;

`ifdef HEX_DISPLAY_BLINK_EN
    modport master (output load, value, dec_mode, blank_lz, blink, input busy, HEX);
    modport slave  (input load, value, dec_mode, blank_lz, blink, output busy, HEX);
`else
    modport master (output load, value, dec_mode, blank_lz, input busy, HEX);
    modport slave  (input load, value, dec_mode, blank_lz, output busy, HEX);
`endif
endinterface

// File: rtl/hex_display_ctrl.sv
// Seven-segment controller: hex or decimal (sequential double-dabble) display of one value.
// Optional blinking of the whole display is enabled with the macro HEX_DISPLAY_BLINK_EN.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6
`ifdef HEX_DISPLAY_BLINK_EN
    ,
    parameter int BLINK_DIV  = 25_000_000
`endif
) (
    input logic          clk,
    input logic          reset,
    hex_display_if.slave bus
);
    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int HEX_W  = 7 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [DATA_W-1:0] MAX_DEC = DATA_W'(pow10(NUM_DIGITS) - 64'd1);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Walk from the top digit down; blanking stops at the first non-zero digit or digit 0.
    function automatic logic [HEX_W-1:0] render(input logic [DATA_W-1:0] digits,
                                                input logic blank);
        logic [HEX_W-1:0] segs;
        logic             lead;
        segs = '1;
        lead = blank;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (lead && (i != 0) && (digits[4*i +: 4] == 4'h0)) begin
                segs[7*i +: 7] = SEG_BLANK;
            end else begin
                segs[7*i +: 7] = glyph(digits[4*i +: 4]);
                lead = 1'b0;
            end
        end
        return segs;
    endfunction

    function automatic logic [DATA_W-1:0] dabble_adjust(input logic [DATA_W-1:0] bcd);
        logic [DATA_W-1:0] r;
        r = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] bcd_q, bcd_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] bcd_adj;
    logic              blank_q, blank_d;
    logic              ovf_q, ovf_d;
    logic [HEX_W-1:0]  hex_q, hex_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        sh_d    = sh_q;
        blank_d = blank_q;
        ovf_d   = ovf_q;
        hex_d   = hex_q;
        bcd_adj = dabble_adjust(bcd_q);
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    if (bus.dec_mode) begin
                        blank_d = bus.blank_lz;
                        sh_d    = bus.value;
                        bcd_d   = '0;
                        cnt_d   = CNT_W'(DATA_W);
                        ovf_d   = (bus.value > MAX_DEC);
                        state_d = CONV;
                    end else begin
                        hex_d = render(bus.value, bus.blank_lz);
                    end
                end
            end
            CONV: begin
                if (cnt_q == '0) begin
                    state_d = UPDATE;
                end else begin
                    bcd_d = {bcd_adj[DATA_W-2:0], sh_q[DATA_W-1]};
                    sh_d  = {sh_q[DATA_W-2:0], 1'b0};
                    cnt_d = cnt_q - 1'b1;
                end
            end
            UPDATE: begin
                hex_d   = ovf_q ? {NUM_DIGITS{SEG_DASH}} : render(bcd_q, blank_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Registered busy trails the state by one edge and drops together with the HEX write.
        busy_d = (state_q != IDLE) && (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hex_q   <= '1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        bcd_q   <= bcd_d;
        sh_q    <= sh_d;
        blank_q <= blank_d;
        ovf_q   <= ovf_d;
    end

    assign bus.busy = busy_q;

`ifdef HEX_DISPLAY_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               accept;

    always_comb begin
        accept      = (state_q == IDLE) && bus.load;
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (accept) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign bus.HEX = (bus.blink && phase_q) ? '1 : hex_q;
`else
    assign bus.HEX = hex_q;
`endif
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized bench for hex_display_ctrl against a digit-level reference model.
module tb_hex_display_ctrl;
    localparam int ND     = 6;
    localparam int DW     = 4 * ND;
    localparam int HW     = 7 * ND;
    localparam int CONV_C = DW + 1;

    localparam logic [6:0] GLYPH [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [HW-1:0] shown;

    hex_display_if #(.NUM_DIGITS(ND)) bus ();

    hex_display_ctrl #(.NUM_DIGITS(ND)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Display expected for a value: digits by plain arithmetic, then glyphs and blanking.
    function automatic logic [HW-1:0] model(input logic [DW-1:0] v, input bit dec, input bit blank);
        int dig [ND];
        int msd;
        longint unsigned x;
        logic [HW-1:0] r;
        x = longint'(v);
        if (dec && x > 64'd999999) return {ND{7'b0111111}};
        for (int i = 0; i < ND; i++) begin
            if (dec) begin
                dig[i] = int'(x % 10);
                x = x / 10;
            end else begin
                dig[i] = int'((v >> (4 * i)) & 24'hF);
            end
        end
        msd = 0;
        for (int i = 0; i < ND; i++) if (dig[i] != 0) msd = i;
        for (int i = 0; i < ND; i++) r[7*i +: 7] = (blank && i > msd) ? 7'b1111111 : GLYPH[dig[i]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hex_load(input logic [DW-1:0] v, input bit blank);
        bus.load     = 1'b1;
        bus.value    = v;
        bus.dec_mode = 1'b0;
        bus.blank_lz = blank;
        tick();
        bus.load = 1'b0;
        shown = model(v, 1'b0, blank);
        check("hex_busy", 64'(bus.busy), 64'd0);
        check("hex_disp", 64'(bus.HEX), 64'(shown));
    endtask

    task automatic dec_load(input logic [DW-1:0] v, input bit blank, input bit poke);
        logic [HW-1:0] prev;
        prev = shown;
        bus.load     = 1'b1;
        bus.value    = v;
        bus.dec_mode = 1'b1;
        bus.blank_lz = blank;
        tick();
        bus.load = 1'b0;
        for (int k = 1; k <= CONV_C + 1; k++) begin
            bus.dec_mode = 1'($urandom);
            bus.blank_lz = 1'($urandom);
            bus.value    = DW'($urandom);
            if (poke && k == 5) bus.load = 1'b1;
            tick();
            bus.load = 1'b0;
            if (k <= CONV_C) begin
                check("dec_busy", 64'(bus.busy), 64'd1);
                check("dec_hold", 64'(bus.HEX), 64'(prev));
            end else begin
                shown = model(v, 1'b1, blank);
                check("dec_busy_end", 64'(bus.busy), 64'd0);
                check("dec_disp", 64'(bus.HEX), 64'(shown));
            end
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        checks       = 0;
        failures     = 0;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.dec_mode = 1'b0;
        bus.blank_lz = 1'b0;
        reset        = 1'b1;
        tick();
        tick();
        check("rst_hex", 64'(bus.HEX), 64'(HW'('1)));
        check("rst_busy", 64'(bus.busy), 64'd0);
        reset = 1'b0;
        shown = '1;

        hex_load(24'h00A3F0, 1'b0);
        check("a3f0_digits", 64'(bus.HEX),
              64'({7'b1000000, 7'b1000000, 7'b0001000, 7'b0110000, 7'b0001110, 7'b1000000}));
        hex_load(24'h00A3F0, 1'b1);
        check("a3f0_blank", 64'(bus.HEX),
              64'({7'b1111111, 7'b1111111, 7'b0001000, 7'b0110000, 7'b0001110, 7'b1000000}));
        hex_load(24'h000000, 1'b1);
        check("zero_blank", 64'(bus.HEX), 64'({{5{7'b1111111}}, 7'b1000000}));

        dec_load(24'd1234, 1'b0, 1'b1);
        check("d1234", 64'(bus.HEX),
              64'({7'b1000000, 7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));
        dec_load(24'd999999, 1'b0, 1'b0);
        check("d999999", 64'(bus.HEX), 64'({ND{7'b0010000}}));
        dec_load(24'd1000000, 1'b1, 1'b0);
        check("d_ovf", 64'(bus.HEX), 64'({ND{7'b0111111}}));
        dec_load(24'd0, 1'b1, 1'b0);

        // Back-to-back hex loads with load held high.
        bus.load = 1'b1;
        bus.dec_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = DW'($urandom);
            bus.value    = v;
            bus.blank_lz = 1'($urandom);
            shown = model(v, 1'b0, bus.blank_lz);
            tick();
            check("b2b_disp", 64'(bus.HEX), 64'(shown));
        end
        bus.load = 1'b0;
        tick();
        tick();
        check("hold", 64'(bus.HEX), 64'(shown));

        for (int i = 0; i < 20; i++) begin
            v = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom);
            hex_load(v, 1'($urandom));
        end
        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 2))
                0:       v = DW'($urandom_range(0, 999));
                1:       v = DW'($urandom_range(0, 999999));
                default: v = DW'($urandom);
            endcase
            dec_load(v, 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of a conversion aborts it.
        bus.load     = 1'b1;
        bus.value    = 24'd424242;
        bus.dec_mode = 1'b1;
        bus.blank_lz = 1'b0;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        reset = 1'b1;
        tick();
        check("midrst_hex", 64'(bus.HEX), 64'(HW'('1)));
        check("midrst_busy", 64'(bus.busy), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < CONV_C + 4; k++) tick();
        check("midrst_stay_hex", 64'(bus.HEX), 64'(HW'('1)));
        check("midrst_stay_busy", 64'(bus.busy), 64'd0);
        hex_load(24'h5C1E07, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Multi-digit seven-segment display controller driving NUM_DIGITS active-low displays from one binary value. Shows the value in hex or in decimal; decimal uses a sequential double-dabble binary-to-BCD converter. Optional leading-zero blanking; all segment outputs are registered. Sits between the CPU's memory-mapped display register and the board HEX pins.

Parameters:
NUM_DIGITS, 6, number of seven-segment digits driven
DATA_W, 4*NUM_DIGITS, width of the value input (derived; not overridden independently)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
load  input  1  single-cycle strobe; captures value, dec_mode and blank_lz
value  input  DATA_W  unsigned binary value to display
dec_mode  input  1  0 = hex, 1 = decimal
blank_lz  input  1  1 = blank leading zero digits
busy  output  1  decimal conversion in progress; load ignored while high
HEX  output  7*NUM_DIGITS  segments, active-low, bit order gfedcba; digit i at HEX[7i+6:7i]; digit 0 is least significant

Behaviour:
- Reset and clock: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: HEX all ones (every digit blank, 7'b1111111); busy 0; FSM in IDLE; shift counter 0. Reset during CONV aborts the conversion with the same result.
- Glyphs: 0-F use the standard active-low table (0 = 1000000, 1 = 1111001, ..., 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110). Blank = 1111111. Dash = 0111111.
- FSM states: IDLE, CONV, UPDATE.
- IDLE, load=1 and dec_mode=0:
  - Nibble i of value goes to digit i; HEX updates on the next edge (latency 1).
  - busy never asserts; the FSM stays in IDLE.
- IDLE, load=1 and dec_mode=1:
  - Capture value and blank_lz; clear the BCD register (4*NUM_DIGITS bits).
  - Go to CONV with the counter set to DATA_W.
  - Overflow flag = (value > 10^NUM_DIGITS - 1), computed at capture.
- CONV, one step per cycle:
  - Add 3 to every BCD nibble that is >= 5.
  - Shift {BCD, shift reg} left by 1 and decrement the counter.
  - When the counter reaches 0, go to UPDATE.
- UPDATE:
  - Write HEX from BCD, or all dashes if the overflow flag is set; then go to IDLE.
- Decimal timing, load sampled at edge N:
  - busy = 1 from N+1 through N+DATA_W+1.
  - New HEX and busy = 0 from edge N+DATA_W+2.
- load while busy=1 is ignored; captured state is not disturbed.
- load in IDLE is always accepted, including back-to-back hex loads; each load updates on the next edge.
- dec_mode and blank_lz are sampled only at load; later changes have no effect until the next load.
- Leading-zero blanking (blank_lz=1):
  - Digits above the most significant non-zero digit are driven blank.
  - Digit 0 is always shown, so value 0 displays "0".
  - Not applied to the overflow dash pattern.
- HEX holds its last written value between loads.

Optional Feature:
Macro HEX_DISPLAY_BLINK_EN.
- Defined:
  - Adds parameter BLINK_DIV (default 25_000_000) and input blink (1 bit).
  - A free-running counter wraps every BLINK_DIV cycles and toggles a phase bit. Counter and phase clear on reset and on any accepted load; phase 0 = shown.
  - While blink=1 and phase=1, HEX is driven all blank. The stored display value is unaffected, and the digits reappear when phase returns to 0 or blink drops.
- Undefined: no blink port, no counter; HEX is always the stored value.

Test Plan:
- Reset held 2 cycles -> HEX = all ones (42 bits), busy = 0; assert reset mid-CONV -> same values on the next edge, and a subsequent hex load works.
- Hex load value=24'h00A3F0, blank_lz=0 -> one cycle later digits 0..5 = 1000000, 0001110, 0110000, 0001000, 1000000, 1000000.
- Same value with blank_lz=1 -> digits 4 and 5 = 1111111, digits 0..3 unchanged; then value=0 with blank_lz=1 -> digit 0 = 1000000, others blank.
- Decimal load value=24'd1234, blank_lz=0:
  - busy high for 25 cycles.
  - From edge N+26, digits 0..5 = 4, 3, 2, 1, 0, 0 glyphs.
  - Second load pulsed at N+5 is ignored.
- Decimal load value=24'd999999 -> digits all 9 (0010000); value=24'd1000000 -> all digits 0111111, even with blank_lz=1.
- HEX_DISPLAY_BLINK_EN with BLINK_DIV=4, blink=1 -> HEX alternates shown/blank every 4 cycles; load mid-blank -> shown phase restarts next cycle.
